// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared types and helpers for the memory arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } owner_t;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    // Two-way round-robin: whoever did not win last time wins now.
    function automatic owner_t rr_pick(input owner_t last_gnt);
        return (last_gnt == OWN_CPU) ? OWN_EXT : OWN_CPU;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter
// Brief  : Round-robin arbiter sharing one single-port memory between the CPU
//          and an external requester, with a bounded external burst lock.
// Rev    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              ext_req,
    input  logic              ext_wr,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_lock,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,

    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,

    output logic              locked
);
    import cpu_pkg::owner_t;
    import cpu_pkg::lock_state_t;
    import cpu_pkg::OWN_NONE;
    import cpu_pkg::OWN_CPU;
    import cpu_pkg::OWN_EXT;
    import cpu_pkg::UNLOCKED;
    import cpu_pkg::LOCKED;
    import cpu_pkg::rr_pick;

    localparam logic [7:0] c_LOCK_MAX = 8'(LOCK_MAX);

    lock_state_t r_lock_state;
    lock_state_t w_lock_state_nxt;
    logic [7:0]  r_lock_cnt;
    logic [7:0]  w_lock_cnt_nxt;
    owner_t      r_last_gnt;
    owner_t      w_last_gnt_nxt;
    owner_t      r_rd_owner;
    owner_t      w_rd_owner_nxt;
    owner_t      w_gnt_sel;

    logic w_locked;
    logic w_at_max;
    logic w_any_gnt;
    logic w_wr_sel;

    assign w_locked = (r_lock_state == LOCKED);
    assign w_at_max = (r_lock_cnt == c_LOCK_MAX);

    // While the lock is held the CPU only gets in on the forced slot.
    always_comb begin : p_arbitrate
        w_gnt_sel = OWN_NONE;
        if (w_locked && ext_lock) begin
            if (w_at_max && cpu_req) begin
                w_gnt_sel = OWN_CPU;
            end else if (ext_req) begin
                w_gnt_sel = OWN_EXT;
            end
        end else if (cpu_req && ext_req) begin
            w_gnt_sel = rr_pick(r_last_gnt);
        end else if (cpu_req) begin
            w_gnt_sel = OWN_CPU;
        end else if (ext_req) begin
            w_gnt_sel = OWN_EXT;
        end
    end

    assign cpu_gnt   = (w_gnt_sel == OWN_CPU);
    assign ext_gnt   = (w_gnt_sel == OWN_EXT);
    assign w_any_gnt = cpu_gnt | ext_gnt;
    assign w_wr_sel  = cpu_gnt ? cpu_wr : ext_wr;

    assign mem_rd   = w_any_gnt & ~w_wr_sel;
    assign mem_wr   = w_any_gnt &  w_wr_sel;
    assign mem_addr = cpu_gnt ? cpu_addr  : (ext_gnt ? ext_addr  : '0);
    assign mem_din  = cpu_gnt ? cpu_wdata : (ext_gnt ? ext_wdata : '0);

    always_comb begin : p_lock_nxt
        w_lock_state_nxt = r_lock_state;
        w_lock_cnt_nxt   = r_lock_cnt;
        case (r_lock_state)
            UNLOCKED: begin
                if (ext_gnt && ext_lock) begin
                    w_lock_state_nxt = LOCKED;
                    w_lock_cnt_nxt   = 8'd1;
                end
            end
            LOCKED: begin
                if (!ext_lock) begin
                    w_lock_state_nxt = UNLOCKED;
                    w_lock_cnt_nxt   = 8'd0;
                end else if (cpu_gnt) begin
                    w_lock_cnt_nxt   = 8'd0;
                end else if (ext_gnt && !w_at_max) begin
                    w_lock_cnt_nxt   = r_lock_cnt + 8'd1;
                end
            end
            default: begin
                w_lock_state_nxt = UNLOCKED;
                w_lock_cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_comb begin : p_owner_nxt
        w_last_gnt_nxt = r_last_gnt;
        w_rd_owner_nxt = OWN_NONE;
        if (w_any_gnt) begin
            w_last_gnt_nxt = w_gnt_sel;
        end
        if (mem_rd) begin
            w_rd_owner_nxt = w_gnt_sel;
        end
    end

    always_ff @(posedge clk) begin : p_regs
        if (rst) begin
            r_lock_state <= UNLOCKED;
            r_lock_cnt   <= 8'd0;
            r_last_gnt   <= OWN_EXT;
            r_rd_owner   <= OWN_NONE;
        end else begin
            r_lock_state <= w_lock_state_nxt;
            r_lock_cnt   <= w_lock_cnt_nxt;
            r_last_gnt   <= w_last_gnt_nxt;
            r_rd_owner   <= w_rd_owner_nxt;
        end
    end

    // A return still in flight when reset rises is suppressed immediately.
    assign cpu_rvalid = ~rst & (r_rd_owner == OWN_CPU);
    assign ext_rvalid = ~rst & (r_rd_owner == OWN_EXT);
    assign cpu_rdata  = cpu_rvalid ? mem_dout : '0;
    assign ext_rdata  = ext_rvalid ? mem_dout : '0;

    assign locked = w_locked;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_arbiter
// Brief  : Self-checking bench for mem_arbiter with a rule-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW       = 5;
    localparam int DW       = 8;
    localparam int LOCK_MAX = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0, cpu_wr = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          ext_req = 1'b0, ext_wr = 1'b0, ext_lock = 1'b0;
    logic [AW-1:0] ext_addr = '0;
    logic [DW-1:0] ext_wdata = '0;
    logic          ext_gnt, ext_rvalid;
    logic [DW-1:0] ext_rdata;
    logic          mem_rd, mem_wr, locked;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_wr(ext_wr), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .ext_lock(ext_lock),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .locked(locked)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        return (i == 3) ? 8'hA5 : 8'(8'h10 + i);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // 32x8 memory with registered read
    logic [DW-1:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = init_val(i);
        mem_dout = '0;
        forever begin
            @(posedge clk);
            if (mem_wr) mem[mem_addr] <= mem_din;
            if (mem_rd) mem_dout <= mem[mem_addr];
        end
    end

    // Reference model: lock ownership, grants-in-lock, last winner, pending read.
    logic [DW-1:0] mm [32];
    bit   m_valid = 0;
    bit   m_locked, m_last_ext;
    int   m_cnt, m_rd;
    logic [DW-1:0] m_rdata;
    bit   ecg, eeg, ecv, eev, erd, ewr;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edin;
    bit   p_cpu, p_ext, p_cwr, p_ewr;
    logic [AW-1:0] p_caddr, p_eaddr;
    logic [DW-1:0] p_cdata, p_edata;

    initial begin
        for (int i = 0; i < 32; i++) mm[i] = init_val(i);
        p_cpu = 0; p_ext = 0;
        forever begin
            @(negedge clk);
            ecg = 0; eeg = 0;
            if (m_locked && ext_lock) begin
                if (m_cnt < LOCK_MAX) eeg = ext_req;
                else if (cpu_req)     ecg = 1;
                else                  eeg = ext_req;
            end else if (cpu_req && ext_req) begin
                ecg = m_last_ext;
                eeg = !m_last_ext;
            end else begin
                ecg = cpu_req;
                eeg = ext_req;
            end
            erd   = (ecg && !cpu_wr) || (eeg && !ext_wr);
            ewr   = (ecg &&  cpu_wr) || (eeg &&  ext_wr);
            eaddr = ecg ? cpu_addr  : (eeg ? ext_addr  : '0);
            edin  = ecg ? cpu_wdata : (eeg ? ext_wdata : '0);
            ecv   = !rst && (m_rd == 1);
            eev   = !rst && (m_rd == 2);
            if (m_valid) begin
                check("cpu_gnt",    cpu_gnt,    ecg);
                check("ext_gnt",    ext_gnt,    eeg);
                check("mem_rd",     mem_rd,     erd);
                check("mem_wr",     mem_wr,     ewr);
                check("mem_addr",   mem_addr,   eaddr);
                check("mem_din",    mem_din,    edin);
                check("locked",     locked,     m_locked);
                check("cpu_rvalid", cpu_rvalid, ecv);
                check("ext_rvalid", ext_rvalid, eev);
                check("cpu_rdata",  cpu_rdata,  ecv ? m_rdata : 8'h00);
                check("ext_rdata",  ext_rdata,  eev ? m_rdata : 8'h00);
                if (!rst && p_cpu && cpu_req)
                    check("cpu_stable", {cpu_wr, cpu_addr, cpu_wdata}, {p_cwr, p_caddr, p_cdata});
                if (!rst && p_ext && ext_req)
                    check("ext_stable", {ext_wr, ext_addr, ext_wdata}, {p_ewr, p_eaddr, p_edata});
            end
            p_cpu = !rst && cpu_req && !cpu_gnt;
            p_ext = !rst && ext_req && !ext_gnt;
            p_cwr = cpu_wr; p_caddr = cpu_addr; p_cdata = cpu_wdata;
            p_ewr = ext_wr; p_eaddr = ext_addr; p_edata = ext_wdata;
            if (rst) begin
                m_locked = 0; m_cnt = 0; m_last_ext = 1; m_rd = 0; m_rdata = '0;
                m_valid  = 1;
            end else begin
                m_rd = (ecg && !cpu_wr) ? 1 : ((eeg && !ext_wr) ? 2 : 0);
                if (ecg) begin
                    if (cpu_wr) mm[cpu_addr] = cpu_wdata; else m_rdata = mm[cpu_addr];
                    m_last_ext = 0;
                end
                if (eeg) begin
                    if (ext_wr) mm[ext_addr] = ext_wdata; else m_rdata = mm[ext_addr];
                    m_last_ext = 1;
                end
                if (!m_locked) begin
                    if (eeg && ext_lock) begin m_locked = 1; m_cnt = 1; end
                end else if (!ext_lock) begin
                    m_locked = 0; m_cnt = 0;
                end else if (ecg) begin
                    m_cnt = 0;
                end else if (eeg && m_cnt < LOCK_MAX) begin
                    m_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        cpu_req = 0; cpu_wr = 0; ext_req = 0; ext_wr = 0; ext_lock = 0;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1;
        tick();
        rst = 0;
    endtask

    int  n_ext_before, cpu_at;
    bit  got_gnt, g_ext, ext_after;

    initial begin
        tick(); tick();
        rst = 0;

        // Single CPU read
        cpu_req = 1; cpu_wr = 0; cpu_addr = 5'h03;
        @(negedge clk);
        check("t1_cpu_gnt", cpu_gnt, 1);
        check("t1_mem_rd", mem_rd, 1);
        check("t1_mem_addr", mem_addr, 5'h03);
        tick();
        cpu_req = 0;
        @(negedge clk);
        check("t1_cpu_rvalid", cpu_rvalid, 1);
        check("t1_cpu_rdata", cpu_rdata, 8'hA5);
        check("t1_ext_rdata", ext_rdata, 8'h00);
        tick();

        // Continuous contention alternates, starting with CPU
        do_reset();
        cpu_req = 1; cpu_wr = 0; cpu_addr = 5'h01;
        ext_req = 1; ext_wr = 1; ext_addr = 5'h02; ext_wdata = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_cpu_gnt", cpu_gnt, (i % 2) == 0);
            check("t2_mem_wr", mem_wr, (i % 2) == 1);
            if ((i % 2) == 1) check("t2_mem_din", mem_din, 8'h3C);
            tick();
        end
        idle_all();
        tick();

        // Locked burst bounded by a forced CPU slot
        do_reset();
        ext_req = 1; ext_wr = 1; ext_lock = 1; ext_addr = 5'h10; ext_wdata = 8'h80;
        n_ext_before = 0; cpu_at = -1; ext_after = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            g_ext = ext_gnt;
            if (i > 0) check("t3_locked", locked, 1);
            if (cpu_gnt && cpu_at < 0) cpu_at = i;
            if (ext_gnt && cpu_at < 0) n_ext_before++;
            if (i == 9) ext_after = ext_gnt;
            tick();
            if (i == 0) begin cpu_req = 1; cpu_wr = 0; cpu_addr = 5'h01; end
            if (g_ext) begin ext_addr = ext_addr + 5'd1; ext_wdata = ext_wdata + 8'd1; end
        end
        check("t3_ext_before_cpu", n_ext_before, 8);
        check("t3_cpu_slot", cpu_at, 8);
        check("t3_ext_resumes", ext_after, 1);
        idle_all();
        tick(); tick();

        // Lock held without requests stalls the CPU
        do_reset();
        ext_req = 1; ext_wr = 1; ext_lock = 1; ext_addr = 5'h08; ext_wdata = 8'h55;
        @(negedge clk);
        check("t4_entry_gnt", ext_gnt, 1);
        tick();
        ext_req = 0;
        cpu_req = 1; cpu_wr = 0; cpu_addr = 5'h02;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_cpu_stalled", cpu_gnt, 0);
            check("t4_locked", locked, 1);
            tick();
        end
        ext_lock = 0;
        @(negedge clk);
        got_gnt = cpu_gnt;
        tick();
        @(negedge clk);
        got_gnt = got_gnt | cpu_gnt;
        check("t4_unlocked", locked, 0);
        check("t4_cpu_served", got_gnt, 1);
        tick();
        idle_all();
        tick();

        // Reset drops an in-flight read and releases a lock
        do_reset();
        cpu_req = 1; cpu_wr = 0; cpu_addr = 5'h07;
        @(negedge clk);
        check("t5_cpu_gnt", cpu_gnt, 1);
        tick();
        cpu_req = 0; rst = 1;
        @(negedge clk);
        check("t5_rvalid_rst", cpu_rvalid, 0);
        tick();
        rst = 0;
        @(negedge clk);
        check("t5_rvalid_after", cpu_rvalid, 0);
        check("t5_locked", locked, 0);
        tick();
        ext_req = 1; ext_wr = 1; ext_lock = 1; ext_addr = 5'h09; ext_wdata = 8'h99;
        tick();
        ext_req = 0; rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        check("t5_lock_released", locked, 0);
        tick();
        cpu_req = 1; cpu_wr = 0; cpu_addr = 5'h00;
        ext_req = 1; ext_wr = 0; ext_addr = 5'h01;
        @(negedge clk);
        check("t5_cpu_wins", cpu_gnt, 1);
        tick();
        idle_all();
        tick();

        // Pipelined reads
        do_reset();
        cpu_req = 1; cpu_wr = 0; cpu_addr = 5'h04;
        @(negedge clk);
        check("t6_gnt0", cpu_gnt, 1);
        tick();
        cpu_req = 0; ext_req = 1; ext_wr = 0; ext_addr = 5'h05;
        @(negedge clk);
        check("t6_gnt1", ext_gnt, 1);
        check("t6_cpu_rvalid0", cpu_rvalid, 1);
        check("t6_cpu_rdata0", cpu_rdata, 8'h14);
        tick();
        ext_req = 0; cpu_req = 1; cpu_addr = 5'h06;
        @(negedge clk);
        check("t6_gnt2", cpu_gnt, 1);
        check("t6_ext_rvalid", ext_rvalid, 1);
        check("t6_ext_rdata", ext_rdata, 8'h15);
        check("t6_cpu_rdata_zero", cpu_rdata, 8'h00);
        tick();
        cpu_req = 0;
        @(negedge clk);
        check("t6_cpu_rvalid2", cpu_rvalid, 1);
        check("t6_cpu_rdata2", cpu_rdata, 8'h16);
        check("t6_ext_rdata_zero", ext_rdata, 8'h00);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
